// File: rtl/mem_init_ram.sv
// mem_init_ram: simple-dual-port synchronous RAM with a hardware init fill.
// After reset, or on init_req, every word is written with INIT_VALUE, one word
// per clock. User writes have per-byte enables. Reads return data after
// RD_LATENCY clocks (1 or 2), marked by rd_valid.
// Optional feature macro: MEM_PARITY_EN. It adds per-byte even parity storage,
// the wr_par_inv error-injection input and the rd_par_err output.

module mem_init_ram #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b1}},
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init_req,
  output logic                      busy,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic [DATA_WIDTH-1:0]     wr_data,
`ifdef MEM_PARITY_EN
  input  logic                      wr_par_inv,
  output logic                      rd_par_err,
`endif
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  // Parameter legality checks, resolved at elaboration
  if ((DATA_WIDTH == 0) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
    $error("mem_init_ram: DATA_WIDTH must be a non-zero multiple of 8");
  end

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [ADDR_WIDTH-1:0]   cnt_nxt;

  logic                    init_we;
  logic                    user_we;
  logic                    rd_fire;
  logic [DATA_WIDTH-1:0]   arr_data;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef MEM_PARITY_EN
  logic [NBYTES-1:0]       mem_par [DEPTH];
  logic                    arr_err;

  // Even parity bit per byte: the byte plus its parity bit hold an even count of ones
  function automatic logic [NBYTES-1:0] byte_par(input logic [DATA_WIDTH-1:0] d);
    logic [NBYTES-1:0] p;
    p = '0;
    for (int k = 0; k < NBYTES; k++) begin
      p[k] = ^d[8*k +: 8];
    end
    return p;
  endfunction
`endif

  // Init sequencer state, fill counter and registered busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == ST_INIT);
    end
  end

  // Next-state logic: walk every address once, then idle until init_req
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + ADDR_WIDTH'(1);
        if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      ST_IDLE: begin
        if (init_req) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Fill writes are held off while rst is high so reset alone never alters the array
  assign init_we = (state == ST_INIT) && !rst;
  assign user_we = wr_en && !busy;
  assign rd_fire = rd_en && !busy;

  // Array write port: init fill has priority; user writes honour byte enables
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[cnt] <= INIT_VALUE;
`ifdef MEM_PARITY_EN
      mem_par[cnt] <= byte_par(INIT_VALUE);
`endif
    end else if (user_we) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (wr_be[k]) begin
          mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
`ifdef MEM_PARITY_EN
          mem_par[wr_addr][k] <= (^wr_data[8*k +: 8]) ^ wr_par_inv;
`endif
        end
      end
    end
  end

  // Array read port; sampled by the output pipeline, giving read-first behaviour
  assign arr_data = mem[rd_addr];
`ifdef MEM_PARITY_EN
  assign arr_err  = |(mem_par[rd_addr] ^ byte_par(arr_data));
`endif

  if (RD_LATENCY == 1) begin : g_lat1
    // Single output register stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_valid   <= 1'b0;
        rd_data    <= '0;
`ifdef MEM_PARITY_EN
        rd_par_err <= 1'b0;
`endif
      end else begin
        rd_valid   <= rd_fire;
        if (rd_fire) begin
          rd_data <= arr_data;
        end
`ifdef MEM_PARITY_EN
        rd_par_err <= rd_fire && arr_err;
`endif
      end
    end
  end else if (RD_LATENCY == 2) begin : g_lat2
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
`ifdef MEM_PARITY_EN
    logic                  s1_err;
`endif
    // Array output register followed by the output register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid   <= 1'b0;
        s1_data    <= '0;
        rd_valid   <= 1'b0;
        rd_data    <= '0;
`ifdef MEM_PARITY_EN
        s1_err     <= 1'b0;
        rd_par_err <= 1'b0;
`endif
      end else begin
        s1_valid <= rd_fire;
        if (rd_fire) begin
          s1_data <= arr_data;
        end
        rd_valid <= s1_valid;
        if (s1_valid) begin
          rd_data <= s1_data;
        end
`ifdef MEM_PARITY_EN
        s1_err     <= rd_fire && arr_err;
        rd_par_err <= s1_valid && s1_err;
`endif
      end
    end
  end else begin : g_bad_lat
    $error("mem_init_ram: RD_LATENCY must be 1 or 2");
  end

endmodule

// File: tb/tb_mem_init_ram.sv
// tb_mem_init_ram: directed self-checking bench for mem_init_ram.
// Instance a uses RD_LATENCY=1, instance b uses RD_LATENCY=2.

module tb_mem_init_ram;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned NB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance a (latency 1)
  logic          a_rst, a_init_req, a_busy, a_wr_en, a_rd_en, a_rd_valid;
  logic [AW-1:0] a_wr_addr, a_rd_addr;
  logic [NB-1:0] a_wr_be;
  logic [DW-1:0] a_wr_data, a_rd_data;
  // Instance b (latency 2)
  logic          b_rst, b_init_req, b_busy, b_wr_en, b_rd_en, b_rd_valid;
  logic [AW-1:0] b_wr_addr, b_rd_addr;
  logic [NB-1:0] b_wr_be;
  logic [DW-1:0] b_wr_data, b_rd_data;
`ifdef MEM_PARITY_EN
  logic a_wr_par_inv, a_rd_par_err, b_wr_par_inv, b_rd_par_err;
`endif

  mem_init_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_a (
    .clk(clk), .rst(a_rst), .init_req(a_init_req), .busy(a_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_be(a_wr_be), .wr_data(a_wr_data),
`ifdef MEM_PARITY_EN
    .wr_par_inv(a_wr_par_inv), .rd_par_err(a_rd_par_err),
`endif
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid)
  );

  mem_init_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_b (
    .clk(clk), .rst(b_rst), .init_req(b_init_req), .busy(b_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_be(b_wr_be), .wr_data(b_wr_data),
`ifdef MEM_PARITY_EN
    .wr_par_inv(b_wr_par_inv), .rd_par_err(b_rd_par_err),
`endif
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [AW-1:0] addr, input logic [NB-1:0] be,
                         input logic [DW-1:0] data);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_be = be; a_wr_data = data;
    tick();
    a_wr_en = 1'b0; a_wr_be = '0;
  endtask

  // Latency-1 read: result is on the outputs when this returns
  task automatic a_read(input logic [AW-1:0] addr);
    a_rd_en = 1'b1; a_rd_addr = addr;
    tick();
    a_rd_en = 1'b0;
  endtask

  task automatic b_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    b_wr_en = 1'b1; b_wr_addr = addr; b_wr_be = 2'b11; b_wr_data = data;
    tick();
    b_wr_en = 1'b0; b_wr_be = '0;
  endtask

  task automatic test_reset();
    logic exp_busy;
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (2) tick();
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL reset_a_busy got=%0b exp=1", a_busy); end
    checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_a_rd_valid got=%0b exp=0", a_rd_valid); end
    checks++; if (a_rd_data !== 16'h0000) begin failures++; $display("FAIL reset_a_rd_data got=%h exp=0000", a_rd_data); end
    checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL reset_b_busy got=%0b exp=1", b_busy); end
    checks++; if (b_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_b_rd_valid got=%0b exp=0", b_rd_valid); end
    checks++; if (b_rd_data !== 16'h0000) begin failures++; $display("FAIL reset_b_rd_data got=%h exp=0000", b_rd_data); end
`ifdef MEM_PARITY_EN
    checks++; if (a_rd_par_err !== 1'b0) begin failures++; $display("FAIL reset_a_par_err got=%0b exp=0", a_rd_par_err); end
`endif
    a_rst = 1'b0; b_rst = 1'b0;
    // busy must fall exactly 8 clocks after release
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_busy = (k < 8);
      checks++; if (a_busy !== exp_busy) begin failures++; $display("FAIL init_busy_a clk=%0d got=%0b exp=%0b", k, a_busy, exp_busy); end
      checks++; if (b_busy !== exp_busy) begin failures++; $display("FAIL init_busy_b clk=%0d got=%0b exp=%0b", k, b_busy, exp_busy); end
    end
  endtask

  task automatic test_init_fill();
    for (int i = 0; i < 8; i++) begin
      a_rd_en = 1'b1; a_rd_addr = AW'(i);
      tick();
      checks++; if (a_rd_valid !== 1'b1) begin failures++; $display("FAIL fill_valid addr=%0d got=%0b exp=1", i, a_rd_valid); end
      checks++; if (a_rd_data !== 16'hFFFF) begin failures++; $display("FAIL fill_data addr=%0d got=%h exp=ffff", i, a_rd_data); end
    end
    a_rd_en = 1'b0;
    tick();
    checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL fill_valid_drop got=%0b exp=0", a_rd_valid); end
    checks++; if (a_rd_data !== 16'hFFFF) begin failures++; $display("FAIL fill_data_hold got=%h exp=ffff", a_rd_data); end
  endtask

  task automatic test_byte_enable();
    a_write(3'd2, 2'b01, 16'hA5C3);
    a_read(3'd2);
    checks++; if (a_rd_data !== 16'hFFC3) begin failures++; $display("FAIL be_low got=%h exp=ffc3", a_rd_data); end
    a_write(3'd2, 2'b10, 16'h1200);
    a_read(3'd2);
    checks++; if (a_rd_data !== 16'h12C3) begin failures++; $display("FAIL be_high got=%h exp=12c3", a_rd_data); end
    a_write(3'd2, 2'b00, 16'h0000);
    a_read(3'd2);
    checks++; if (a_rd_data !== 16'h12C3) begin failures++; $display("FAIL be_none got=%h exp=12c3", a_rd_data); end
  endtask

  task automatic test_same_cycle();
    a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_be = 2'b11; a_wr_data = 16'h0000;
    a_rd_en = 1'b1; a_rd_addr = 3'd5;
    tick();
    a_wr_en = 1'b0; a_wr_be = '0; a_rd_en = 1'b0;
    checks++; if (a_rd_data !== 16'hFFFF) begin failures++; $display("FAIL rw_same_old got=%h exp=ffff", a_rd_data); end
    a_read(3'd5);
    checks++; if (a_rd_data !== 16'h0000) begin failures++; $display("FAIL rw_same_new got=%h exp=0000", a_rd_data); end
  endtask

  task automatic test_init_req();
    logic exp_busy;
    a_write(3'd3, 2'b11, 16'h1234);
    // Read issued on the accept cycle still completes with pre-init data
    a_init_req = 1'b1; a_rd_en = 1'b1; a_rd_addr = 3'd3;
    tick();
    a_init_req = 1'b0;
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL initreq_busy got=%0b exp=1", a_busy); end
    checks++; if (a_rd_valid !== 1'b1) begin failures++; $display("FAIL initreq_accept_valid got=%0b exp=1", a_rd_valid); end
    checks++; if (a_rd_data !== 16'h1234) begin failures++; $display("FAIL initreq_accept_data got=%h exp=1234", a_rd_data); end
    // User traffic while busy must be ignored; a second init_req mid-fill too
    a_wr_en = 1'b1; a_wr_addr = 3'd3; a_wr_be = 2'b11; a_wr_data = 16'h5555;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_busy = (k < 8);
      checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL busy_no_valid clk=%0d got=%0b exp=0", k, a_rd_valid); end
      checks++; if (a_busy !== exp_busy) begin failures++; $display("FAIL initreq_busy clk=%0d got=%0b exp=%0b", k, a_busy, exp_busy); end
      a_init_req = (k == 3);
    end
    a_rd_en = 1'b0; a_wr_en = 1'b0; a_wr_be = '0; a_init_req = 1'b0;
    a_read(3'd3);
    checks++; if (a_rd_data !== 16'hFFFF) begin failures++; $display("FAIL reinit_addr3 got=%h exp=ffff", a_rd_data); end
    a_read(3'd5);
    checks++; if (a_rd_data !== 16'hFFFF) begin failures++; $display("FAIL reinit_addr5 got=%h exp=ffff", a_rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [3];
    logic exp_busy;
    exp_d[0] = 16'h0011; exp_d[1] = 16'h0022; exp_d[2] = 16'h0033;
    b_write(3'd0, 16'h0011);
    b_write(3'd1, 16'h0022);
    b_write(3'd2, 16'h0033);
    b_rd_en = 1'b1; b_rd_addr = 3'd0;
    tick();
    checks++; if (b_rd_valid !== 1'b0) begin failures++; $display("FAIL lat2_early got=%0b exp=0", b_rd_valid); end
    b_rd_addr = 3'd1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (b_rd_valid !== 1'b1) begin failures++; $display("FAIL lat2_valid idx=%0d got=%0b exp=1", i, b_rd_valid); end
      checks++; if (b_rd_data !== exp_d[i]) begin failures++; $display("FAIL lat2_data idx=%0d got=%h exp=%h", i, b_rd_data, exp_d[i]); end
      if (i == 0) b_rd_addr = 3'd2;
      else b_rd_en = 1'b0;
      tick();
    end
    checks++; if (b_rd_valid !== 1'b0) begin failures++; $display("FAIL lat2_end_valid got=%0b exp=0", b_rd_valid); end
    checks++; if (b_rd_data !== 16'h0033) begin failures++; $display("FAIL lat2_hold got=%h exp=0033", b_rd_data); end
    // Reset in the middle of a read stream
    b_rd_en = 1'b1; b_rd_addr = 3'd0;
    tick();
    b_rd_addr = 3'd1;
    tick();
    checks++; if (b_rd_valid !== 1'b1) begin failures++; $display("FAIL lat2_pre_rst_valid got=%0b exp=1", b_rd_valid); end
    #1;
    b_rst = 1'b1; b_rd_en = 1'b0;
    #1;
    checks++; if (b_rd_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%0b exp=0", b_rd_valid); end
    checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got=%0b exp=1", b_busy); end
    checks++; if (b_rd_data !== 16'h0000) begin failures++; $display("FAIL rst_mid_data got=%h exp=0000", b_rd_data); end
    tick();
    b_rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_busy = (k < 8);
      checks++; if (b_rd_valid !== 1'b0) begin failures++; $display("FAIL rst_flush clk=%0d got=%0b exp=0", k, b_rd_valid); end
      checks++; if (b_busy !== exp_busy) begin failures++; $display("FAIL rst_busy clk=%0d got=%0b exp=%0b", k, b_busy, exp_busy); end
    end
    b_rd_en = 1'b1; b_rd_addr = 3'd0;
    tick();
    b_rd_en = 1'b0;
    tick();
    checks++; if (b_rd_valid !== 1'b1) begin failures++; $display("FAIL rst_reinit_valid got=%0b exp=1", b_rd_valid); end
    checks++; if (b_rd_data !== 16'hFFFF) begin failures++; $display("FAIL rst_reinit_data got=%h exp=ffff", b_rd_data); end
  endtask

`ifdef MEM_PARITY_EN
  task automatic test_parity();
    a_wr_par_inv = 1'b0;
    a_write(3'd4, 2'b11, 16'h00FF);
    a_read(3'd4);
    checks++; if (a_rd_par_err !== 1'b0) begin failures++; $display("FAIL par_clean got=%0b exp=0", a_rd_par_err); end
    a_wr_par_inv = 1'b1;
    a_write(3'd4, 2'b01, 16'h00FF);
    a_wr_par_inv = 1'b0;
    a_read(3'd4);
    checks++; if (a_rd_data !== 16'h00FF) begin failures++; $display("FAIL par_inj_data got=%h exp=00ff", a_rd_data); end
    checks++; if (a_rd_par_err !== 1'b1) begin failures++; $display("FAIL par_inj_err got=%0b exp=1", a_rd_par_err); end
    tick();
    checks++; if (a_rd_par_err !== 1'b0) begin failures++; $display("FAIL par_idle_err got=%0b exp=0", a_rd_par_err); end
    a_write(3'd4, 2'b01, 16'h00FF);
    a_read(3'd4);
    checks++; if (a_rd_par_err !== 1'b0) begin failures++; $display("FAIL par_fixed got=%0b exp=0", a_rd_par_err); end
  endtask
`endif

  initial begin
    a_rst = 1'b1; a_init_req = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
    a_wr_addr = '0; a_rd_addr = '0; a_wr_be = '0; a_wr_data = '0;
    b_rst = 1'b1; b_init_req = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
    b_wr_addr = '0; b_rd_addr = '0; b_wr_be = '0; b_wr_data = '0;
`ifdef MEM_PARITY_EN
    a_wr_par_inv = 1'b0; b_wr_par_inv = 1'b0;
`endif
    test_reset();
    test_init_fill();
    test_byte_enable();
    test_same_cycle();
    test_init_req();
    test_back_to_back();
`ifdef MEM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
